rx_frame_buffer: RTL and testbench

Synthesizable store-and-forward frame buffer on the byte-wise rx path (frame_decode / rx output, BY_BYTE=1 semantics). It captures one complete frame of soc/data/eoc/error events, including a trailing partial byte. It validates the frame and replays it to the consumer as a valid/ready byte stream with last-byte bit count and length. Corrupt, empty or oversize frames are reported and either dropped or forwarded flagged. It sits between the rx decoder and the initiator/command-handling logic.

---
 rtl/rx_frame_buffer.sv | 180 ++++++++++++++++++
 tb/tb_rx_frame_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_buffer.sv
// Store-and-forward buffer for one rx frame: captures soc/data/eoc/error events,
// validates the frame, then replays it as a valid/ready byte stream.
module rx_frame_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int DROP_ERRORED = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_soc,
  input  logic                         rx_eoc,
  input  logic                         rx_error,
  input  logic                         rx_data_valid,
  input  logic [DATA_WIDTH-1:0]        rx_data,
  input  logic [2:0]                   rx_data_bits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [2:0]                   out_last_bits,
  output logic [$clog2(DEPTH+1)-1:0]   out_len,
  output logic                         out_error,
  output logic                         frame_dropped,
  output logic                         rx_overrun
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RECV, OUT} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d;
  logic            bad_q, bad_d, ovf_q, ovf_d, err_q, err_d;
  logic [2:0]      last_bits_q, last_bits_d;
  logic            valid_q, valid_d, dropped_q, dropped_d, overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata, wmask;
  logic                  has_room, last_hs, bad_n, ovf_n;
  logic [LW-1:0]         n_ptr;

  assign has_room = wr_ptr_q < LW'(DEPTH);
  assign last_hs  = valid_q && out_ready && (rd_ptr_q == len_q - LW'(1));

  // Partial last byte: bits at or above rx_data_bits are zeroed on write.
  always_comb begin
    wmask = '1;
    if (rx_data_bits != 3'd0) begin
      for (int i = 0; i < DATA_WIDTH; i++)
        if (i >= int'(rx_data_bits)) wmask[i] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    bad_d       = bad_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    last_bits_d = last_bits_q;
    valid_d     = valid_q;
    dropped_d   = 1'b0;
    overrun_d   = 1'b0;
    we          = 1'b0;
    wdata       = rx_data;
    bad_n       = bad_q | rx_error;
    ovf_n       = ovf_q;
    n_ptr       = wr_ptr_q;
    case (state_q)
      IDLE: begin
        if (rx_soc) begin
          state_d  = RECV;
          wr_ptr_d = '0;
          bad_d    = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RECV: begin
        if (rx_soc) begin
          wr_ptr_d = '0;
          bad_d    = 1'b0;
          ovf_d    = 1'b0;
        end else if (rx_eoc) begin
          last_bits_d = 3'd0;
          if (rx_data_valid) begin
            if (has_room) begin
              we          = 1'b1;
              wdata       = rx_data & wmask;
              n_ptr       = wr_ptr_q + LW'(1);
              last_bits_d = rx_data_bits;
            end else begin
              // Unstored partial byte: the final output byte is a full one.
              ovf_n = 1'b1;
            end
          end
          wr_ptr_d = n_ptr;
          bad_d    = bad_n;
          ovf_d    = ovf_n;
          if (n_ptr == '0 || ((bad_n || ovf_n) && DROP_ERRORED != 0)) begin
            dropped_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d  = OUT;
            len_d    = n_ptr;
            err_d    = bad_n | ovf_n;
            rd_ptr_d = '0;
            valid_d  = 1'b1;
          end
        end else if (rx_error) begin
          bad_d = 1'b1;
        end else if (rx_data_valid) begin
          if (has_room) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (rx_soc) overrun_d = 1'b1;
        if (last_hs) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          rd_ptr_d    = '0;
          len_d       = '0;
          err_d       = 1'b0;
          last_bits_d = 3'd0;
        end else if (valid_q && out_ready) begin
          rd_ptr_d = rd_ptr_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      last_bits_q <= 3'd0;
      valid_q     <= 1'b0;
      dropped_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      last_bits_q <= last_bits_d;
      valid_q     <= valid_d;
      dropped_q   <= dropped_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign out_valid     = valid_q;
  assign out_data      = mem[rd_ptr_q[AW-1:0]];
  assign out_last      = valid_q && (rd_ptr_q == len_q - LW'(1));
  assign out_last_bits = last_bits_q;
  assign out_len       = len_q;
  assign out_error     = err_q;
  assign frame_dropped = dropped_q;
  assign rx_overrun    = overrun_q;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench: dut_a (DEPTH 32, drop bad frames) and dut_b (DEPTH 4, forward
// bad frames flagged) share one stimulus stream; each has its own expected queue.
module tb_rx_frame_buffer;
  logic clk = 1'b0;
  logic rst;
  logic rx_soc, rx_eoc, rx_error, rx_data_valid, out_ready;
  logic [7:0] rx_data;
  logic [2:0] rx_data_bits;

  logic       ov_a, ol_a, oe_a, fd_a, ro_a;
  logic [7:0] od_a;
  logic [2:0] olb_a;
  logic [5:0] len_a;
  logic       ov_b, ol_b, oe_b, fd_b, ro_b;
  logic [7:0] od_b;
  logic [2:0] olb_b;
  logic [2:0] len_b;

  always #5 clk = ~clk;

  rx_frame_buffer #(.DATA_WIDTH(8), .DEPTH(32), .DROP_ERRORED(1)) dut_a (
    .clk(clk), .rst(rst), .rx_soc(rx_soc), .rx_eoc(rx_eoc), .rx_error(rx_error),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_data_bits(rx_data_bits),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a),
    .out_last_bits(olb_a), .out_len(len_a), .out_error(oe_a),
    .frame_dropped(fd_a), .rx_overrun(ro_a));

  rx_frame_buffer #(.DATA_WIDTH(8), .DEPTH(4), .DROP_ERRORED(0)) dut_b (
    .clk(clk), .rst(rst), .rx_soc(rx_soc), .rx_eoc(rx_eoc), .rx_error(rx_error),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_data_bits(rx_data_bits),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_last(ol_b),
    .out_last_bits(olb_b), .out_len(len_b), .out_error(oe_b),
    .frame_dropped(fd_b), .rx_overrun(ro_b));

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [2:0] lb;
    logic [5:0] len;
    logic       err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int nvec = 0, nerr = 0;
  int drop_a = 0, drop_b = 0, ovr_a = 0, ovr_b = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_one(input bit sel, input logic [7:0] d, input logic last,
                         input logic [2:0] lb, input logic [5:0] len, input logic err);
    exp_t  e;
    string p;
    p = sel ? "b" : "a";
    if ((sel ? qb.size() : qa.size()) == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s_unexpected: got byte %0h, expected no output", p, d);
    end else begin
      e = sel ? qb.pop_front() : qa.pop_front();
      cmp({p, "_data"}, 32'(d), 32'(e.d));
      cmp({p, "_last"}, 32'(last), 32'(e.last));
      if (e.last) cmp({p, "_last_bits"}, 32'(lb), 32'(e.lb));
      cmp({p, "_len"}, 32'(len), 32'(e.len));
      cmp({p, "_error"}, 32'(err), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fd_a) drop_a++;
      if (fd_b) drop_b++;
      if (ro_a) ovr_a++;
      if (ro_b) ovr_b++;
      if (ov_a && out_ready) mon_one(1'b0, od_a, ol_a, olb_a, len_a, oe_a);
      if (ov_b && out_ready) mon_one(1'b1, od_b, ol_b, olb_b, {3'b000, len_b}, oe_b);
    end
  end

  task automatic exp_byte(input bit sel, input logic [7:0] d, input logic last,
                          input logic [2:0] lb, input logic [5:0] len, input logic err);
    exp_t e;
    e = '{d: d, last: last, lb: lb, len: len, err: err};
    if (sel) qb.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic ev(input logic soc, input logic eoc, input logic err, input logic dv,
                    input logic [7:0] d, input logic [2:0] bits);
    rx_soc = soc; rx_eoc = eoc; rx_error = err; rx_data_valid = dv;
    rx_data = d; rx_data_bits = bits;
    @(posedge clk); #1;
    rx_soc = 0; rx_eoc = 0; rx_error = 0; rx_data_valid = 0;
    rx_data = 8'h00; rx_data_bits = 3'd0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    cmp({nm, "_pending"}, 32'(qa.size() + qb.size()), 32'd0);
    qa.delete();
    qb.delete();
  endtask

  task automatic pulses(input string nm, input int da, input int db, input int oa, input int ob);
    cmp({nm, "_drop_a"}, 32'(drop_a), 32'(da));
    cmp({nm, "_drop_b"}, 32'(drop_b), 32'(db));
    cmp({nm, "_ovr_a"}, 32'(ovr_a), 32'(oa));
    cmp({nm, "_ovr_b"}, 32'(ovr_b), 32'(ob));
    drop_a = 0; drop_b = 0; ovr_a = 0; ovr_b = 0;
  endtask

  task automatic exp_three(input bit sel);
    exp_byte(sel, 8'h93, 1'b0, 3'd0, 6'd3, 1'b0);
    exp_byte(sel, 8'h20, 1'b0, 3'd0, 6'd3, 1'b0);
    exp_byte(sel, 8'hAB, 1'b1, 3'd0, 6'd3, 1'b0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    rx_soc = 0; rx_eoc = 0; rx_error = 0; rx_data_valid = 0;
    rx_data = 8'h00; rx_data_bits = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_valid_a", 32'(ov_a), 32'd0);
    cmp("rst_valid_b", 32'(ov_b), 32'd0);
    cmp("rst_len_a", 32'(len_a), 32'd0);
    cmp("rst_flags_a", {29'd0, oe_a, fd_a, ro_a}, 32'd0);
    cmp("rst_flags_b", {29'd0, oe_b, fd_b, ro_b}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain 3-byte frame and eoc->out_valid latency
    exp_three(0); exp_three(1);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'h93, 3'd0);
    ev(0, 0, 0, 1, 8'h20, 3'd0);
    ev(0, 0, 0, 1, 8'hAB, 3'd0);
    rx_eoc = 1'b1;
    #1 cmp("t1_valid_before_eoc", 32'(ov_a), 32'd0);
    @(posedge clk); #1;
    rx_eoc = 1'b0;
    cmp("t1_valid_after_eoc", 32'(ov_a), 32'd1);
    drain("t1");
    pulses("t1", 0, 0, 0, 0);

    // REQA 7-bit short frame: 0xA6 masked to 0x26
    exp_byte(0, 8'h26, 1'b1, 3'd7, 6'd1, 1'b0);
    exp_byte(1, 8'h26, 1'b1, 3'd7, 6'd1, 1'b0);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 1, 0, 1, 8'hA6, 3'd7);
    drain("t2");
    pulses("t2", 0, 0, 0, 0);

    // Errored frame: dropped by a, forwarded flagged by b
    exp_byte(1, 8'h50, 1'b1, 3'd0, 6'd1, 1'b1);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'h50, 3'd0);
    ev(0, 0, 1, 0, 8'h00, 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    drain("t3a");
    pulses("t3a", 1, 0, 0, 0);

    // Empty frame: dropped by both
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    drain("t3b");
    pulses("t3b", 1, 1, 0, 0);

    // Six bytes: fits in a, overflows b (DEPTH 4)
    for (int i = 1; i <= 6; i++) exp_byte(0, 8'(i), i == 6, 3'd0, 6'd6, 1'b0);
    for (int i = 1; i <= 4; i++) exp_byte(1, 8'(i), i == 4, 3'd0, 6'd4, 1'b1);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    for (int i = 1; i <= 6; i++) ev(0, 0, 0, 1, 8'(i), 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    drain("t4");
    pulses("t4", 0, 0, 0, 0);

    // Back-pressure with an overrun frame injected during the stall
    out_ready = 1'b0;
    exp_three(0); exp_three(1);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'h93, 3'd0);
    ev(0, 0, 0, 1, 8'h20, 3'd0);
    ev(0, 0, 0, 1, 8'hAB, 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    for (int i = 0; i < 10; i++) begin
      cmp("t5_stall_valid_a", 32'(ov_a), 32'd1);
      cmp("t5_stall_data_a", 32'(od_a), 32'h93);
      cmp("t5_stall_data_b", 32'(od_b), 32'h93);
      if (i == 3) begin
        ev(1, 0, 0, 0, 8'h00, 3'd0);
        ev(0, 0, 0, 1, 8'h11, 3'd0);
        ev(0, 1, 0, 0, 8'h00, 3'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    drain("t5");
    pulses("t5", 0, 0, 1, 1);

    // Restart inside RECV: only the second frame survives
    exp_byte(0, 8'hBB, 1'b1, 3'd0, 6'd1, 1'b0);
    exp_byte(1, 8'hBB, 1'b1, 3'd0, 6'd1, 1'b0);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'hAA, 3'd0);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'hBB, 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    drain("t6a");
    pulses("t6a", 0, 0, 0, 0);

    // Reset mid-RECV: eoc after reset is ignored in IDLE
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'h12, 3'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    cmp("t6b_valid_a", 32'(ov_a), 32'd0);
    cmp("t6b_valid_b", 32'(ov_b), 32'd0);
    pulses("t6b", 0, 0, 0, 0);

    // Reset mid-OUT
    out_ready = 1'b0;
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'h77, 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    cmp("t6c_valid_pre", 32'(ov_a), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp("t6c_valid_a", 32'(ov_a), 32'd0);
    cmp("t6c_valid_b", 32'(ov_b), 32'd0);
    cmp("t6c_len_a", 32'(len_a), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulses("t6c", 0, 0, 0, 0);

    // Normal frame after reset
    exp_byte(0, 8'h5A, 1'b0, 3'd0, 6'd2, 1'b0);
    exp_byte(0, 8'h3C, 1'b1, 3'd0, 6'd2, 1'b0);
    exp_byte(1, 8'h5A, 1'b0, 3'd0, 6'd2, 1'b0);
    exp_byte(1, 8'h3C, 1'b1, 3'd0, 6'd2, 1'b0);
    ev(1, 0, 0, 0, 8'h00, 3'd0);
    ev(0, 0, 0, 1, 8'h5A, 3'd0);
    ev(0, 0, 0, 1, 8'h3C, 3'd0);
    ev(0, 1, 0, 0, 8'h00, 3'd0);
    drain("t6d");
    pulses("t6d", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
